// File: rtl/pe_wb_packer_if.sv
// pe_wb_packer_if: bundles the instruction-start fields, the PE result
// handshake and the VRF write port of the writeback packer.
//   start/vd_addr/vl/vsew/widening : instruction launch (start is a 1-cycle pulse)
//   pe_valid/pe_ready/pe_out/pe_mask : PE result stream
//   wr_en/wr_addr/wr_data/wr_be/wr_ready : VRF word write port
//   busy/done : instruction status
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid (pe_valid / wr_en) and ready (pe_ready / wr_ready) are both 1.
// The source holds its payload stable while valid=1 and ready=0.
interface pe_wb_packer_if #(
  parameter int ADDR_W = 7,
  parameter int VL_W   = 8
);
  logic              start;
  logic [ADDR_W-1:0] vd_addr;
  logic [VL_W-1:0]   vl;
  logic [1:0]        vsew;
  logic [1:0]        widening;
  logic              pe_valid;
  logic              pe_ready;
  logic [31:0]       pe_out;
  logic              pe_mask;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              wr_ready;
  logic              busy;
  logic              done;

  // Driver side (PE / sequencer / VRF model)
  modport master (
    output start, vd_addr, vl, vsew, widening,
    output pe_valid, pe_out, pe_mask, wr_ready,
    input  pe_ready, wr_en, wr_addr, wr_data, wr_be, busy, done
  );

  // Packer side
  modport slave (
    input  start, vd_addr, vl, vsew, widening,
    input  pe_valid, pe_out, pe_mask, wr_ready,
    output pe_ready, wr_en, wr_addr, wr_data, wr_be, busy, done
  );
endinterface

// File: rtl/pe_wb_packer.sv
// pe_wb_packer: packs PE results (EEW = 8/16/32 bits) into 32-bit VRF words
// with per-byte enables; flushes the trailing partial word at vector end.
// Ports:
//   clk         : clock, rising edge
//   n_reset     : asynchronous active-low reset
//   bus         : pe_wb_packer_if.slave (start fields, PE stream, VRF write, status)
//   o_dbg_state : current FSM state (0=IDLE, 1=RUN, 2=DRAIN)
module pe_wb_packer #(
  parameter int ADDR_W = 7,
  parameter int VL_W   = 8
) (
  input  logic              clk,
  input  logic              n_reset,
  pe_wb_packer_if.slave     bus,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [VL_W-1:0]   r_vl, r_elem_cnt;
  logic [1:0]        r_eew;        // 0=8b, 1=16b, 2=32b
  logic [1:0]        r_slot;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [31:0]       r_pack_data;
  logic [3:0]        r_pack_be;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic [3:0]        r_wr_be;
  logic              r_done;

  logic [2:0]  w_eew_sum;
  logic [1:0]  w_eew_in;
  logic [1:0]  w_last_slot;
  logic [31:0] w_field_mask;
  logic [3:0]  w_slot_be;
  logic [1:0]  w_byte_off;
  logic [31:0] w_elem_data;
  logic [31:0] w_new_data;
  logic [3:0]  w_new_be;
  logic        w_out_free, w_accept, w_last_elem, w_word_done, w_start, w_done_nxt;

  // Destination width code saturates at 32 bits (also covers reserved vsew=3).
  assign w_eew_sum = {1'b0, bus.vsew} + {1'b0, bus.widening};
  assign w_eew_in  = (w_eew_sum >= 3'd2) ? 2'd2 : w_eew_sum[1:0];

  always_comb begin
    w_last_slot  = 2'd0;
    w_field_mask = 32'hFFFF_FFFF;
    w_slot_be    = 4'hF;
    w_byte_off   = 2'd0;
    case (r_eew)
      2'd0: begin
        w_last_slot  = 2'd3;
        w_field_mask = 32'h0000_00FF;
        w_slot_be    = 4'b0001 << r_slot;
        w_byte_off   = r_slot;
      end
      2'd1: begin
        w_last_slot  = 2'd1;
        w_field_mask = 32'h0000_FFFF;
        w_slot_be    = 4'b0011 << {r_slot[0], 1'b0};
        w_byte_off   = {r_slot[0], 1'b0};
      end
      default: ;
    endcase
  end

  // Masked-off elements contribute neither data nor enables.
  assign w_elem_data = bus.pe_mask ? ((bus.pe_out & w_field_mask) << {w_byte_off, 3'b000}) : 32'd0;
  assign w_new_data  = r_pack_data | w_elem_data;
  assign w_new_be    = r_pack_be | (bus.pe_mask ? w_slot_be : 4'd0);

  // Output register can take a new word when empty or draining this cycle.
  assign w_out_free  = ~r_wr_en | bus.wr_ready;
  assign w_accept    = (r_state == S_RUN) & bus.pe_valid & w_out_free;
  assign w_last_elem = (r_elem_cnt == (r_vl - VL_W'(1)));
  assign w_word_done = w_accept & ((r_slot == w_last_slot) | w_last_elem);
  // A start landing in the done cycle is ignored (busy is still 1 there).
  assign w_start     = (r_state == S_IDLE) & ~r_done & bus.start;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = (bus.vl == '0) ? S_DRAIN : S_RUN;
      S_RUN:   if (w_accept && w_last_elem) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_out_free) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_vl        <= '0;
      r_elem_cnt  <= '0;
      r_eew       <= 2'd0;
      r_slot      <= 2'd0;
      r_cur_addr  <= '0;
      r_pack_data <= 32'd0;
      r_pack_be   <= 4'd0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= 32'd0;
      r_wr_be     <= 4'd0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_start) begin
        r_vl        <= bus.vl;
        r_eew       <= w_eew_in;
        r_cur_addr  <= bus.vd_addr;
        r_elem_cnt  <= '0;
        r_slot      <= 2'd0;
        r_pack_data <= 32'd0;
        r_pack_be   <= 4'd0;
      end else if (w_accept) begin
        r_elem_cnt <= r_elem_cnt + VL_W'(1);
        r_slot     <= (r_slot == w_last_slot) ? 2'd0 : r_slot + 2'd1;
        if (w_word_done) begin
          r_pack_data <= 32'd0;
          r_pack_be   <= 4'd0;
          r_cur_addr  <= r_cur_addr + ADDR_W'(1);
        end else begin
          r_pack_data <= w_new_data;
          r_pack_be   <= w_new_be;
        end
      end

      // A fully masked word still advances the address but issues no write.
      if (w_word_done) begin
        r_wr_en   <= |w_new_be;
        r_wr_addr <= r_cur_addr;
        r_wr_data <= w_new_data;
        r_wr_be   <= w_new_be;
      end else if (bus.wr_ready) begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign bus.pe_ready = (r_state == S_RUN) & w_out_free;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.wr_be    = r_wr_be;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state != S_IDLE) | r_done;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_pe_wb_packer.sv
module tb_pe_wb_packer;
  localparam int ADDR_W = 7;
  localparam int VL_W   = 8;
  localparam int EXP_W  = ADDR_W + 4 + 32;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic [1:0] dbg_state;

  pe_wb_packer_if #(.ADDR_W(ADDR_W), .VL_W(VL_W)) bus ();

  pe_wb_packer #(.ADDR_W(ADDR_W), .VL_W(VL_W)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] wr_got;
  int n_checks = 0;
  int n_pass   = 0;
  int n_wr     = 0;
  int last_wr_cyc = 0;

  logic [31:0] elem_d [8];
  logic        elem_m [8];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [3:0] be, input logic [31:0] d);
    exp_q.push_back({a, be, d});
  endtask

  // VRF side: every write handshake is compared against the expected queue.
  // A write with an empty queue is compared against zero (a real write has be!=0).
  always @(negedge clk) begin
    if (n_reset && bus.wr_en && bus.wr_ready) begin
      wr_got = {bus.wr_addr, bus.wr_be, bus.wr_data};
      n_wr++;
      last_wr_cyc = cyc;
      if (exp_q.size() == 0) chk_eq("wr_unexpected", wr_got, '0);
      else                   chk_eq("wr_word", wr_got, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_instr(input logic [ADDR_W-1:0] a, input logic [VL_W-1:0] vl,
                             input logic [1:0] sew, input logic [1:0] wid);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.vd_addr = a; bus.vl = vl; bus.vsew = sew; bus.widening = wid;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic send_elem(input logic [31:0] d, input logic m);
    int   n = 0;
    logic rdy = 1'b0;
    bus.pe_valid = 1'b1; bus.pe_out = d; bus.pe_mask = m;
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = bus.pe_ready;
      @(posedge clk); #1;
      n++;
    end
    chk_eq("pe_accept", rdy, 1);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) send_elem(elem_d[i], elem_m[i]);
    bus.pe_valid = 1'b0;
  endtask

  // Holds wr_ready low for the first 3 cycles of the first write.
  task automatic bp_hold3();
    int   n = 0;
    logic seen = 1'b0;
    logic [EXP_W-1:0] snap;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = bus.wr_en;
      n++;
    end
    chk_eq("bp_wr_seen", seen, 1);
    snap = {bus.wr_addr, bus.wr_be, bus.wr_data};
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      chk_eq("bp_pe_ready", bus.pe_ready, 0);
      chk_eq("bp_hold", {bus.wr_en, bus.wr_addr, bus.wr_be, bus.wr_data}, {1'b1, snap});
    end
    @(posedge clk); #1;
    bus.wr_ready = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int   n = 0;
    logic got = 1'b0;
    while (!got && n < 30) begin
      @(negedge clk);
      got = bus.done;
      n++;
    end
    chk_eq({tag, "_done_seen"}, got, 1);
    if (got) begin
      chk_eq({tag, "_done_lat"}, cyc, last_wr_cyc + 1);
      chk_eq({tag, "_busy_in_done"}, bus.busy, 1);
    end
    chk_eq({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  task automatic run_instr(input logic [ADDR_W-1:0] a, input logic [VL_W-1:0] vl,
                           input logic [1:0] sew, input logic [1:0] wid,
                           input int n, input logic bp, input string tag);
    start_instr(a, vl, sew, wid);
    fork
      feed(n);
      if (bp) bp_hold3();
    join
    wait_done(tag);
  endtask

  task automatic check_idle(input string tag);
    chk_eq({tag, "_outs"}, {bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_be,
                            bus.done, bus.busy, bus.pe_ready}, '0);
    chk_eq({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 6; i++) begin
      elem_d[i] = 32'h11 * (i + 1);
      elem_m[i] = 1'b1;
    end
  endtask

  task automatic expect_t1();
    push_exp(7'h10, 4'hF, 32'h4433_2211);
    push_exp(7'h11, 4'h3, 32'h0000_6655);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int wr_before;
  initial begin
    bus.start = 1'b0; bus.vd_addr = '0; bus.vl = '0; bus.vsew = 2'd0; bus.widening = 2'd0;
    bus.pe_valid = 1'b0; bus.pe_out = 32'd0; bus.pe_mask = 1'b0; bus.wr_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    @(negedge clk) n_reset = 1'b1;

    // 8-bit elements, full mask
    load_t1(); expect_t1();
    run_instr(7'h10, 8'd6, 2'd0, 2'd0, 6, 1'b0, "t1");

    // widening 8->16
    elem_d[0] = 32'hAAAA_1234; elem_d[1] = 32'h0000_5678; elem_d[2] = 32'h0000_9ABC;
    elem_m[0] = 1'b1; elem_m[1] = 1'b1; elem_m[2] = 1'b1;
    push_exp(7'h30, 4'hF, 32'h5678_1234);
    push_exp(7'h31, 4'h3, 32'h0000_9ABC);
    run_instr(7'h30, 8'd3, 2'd0, 2'd1, 3, 1'b0, "t2");

    // 32-bit with a masked-off middle element: no write at 0x21
    elem_d[0] = 32'hCAFE_F00D; elem_d[1] = 32'h1234_5678; elem_d[2] = 32'h0BAD_BEEF;
    elem_m[0] = 1'b1; elem_m[1] = 1'b0; elem_m[2] = 1'b1;
    push_exp(7'h20, 4'hF, 32'hCAFE_F00D);
    push_exp(7'h22, 4'hF, 32'h0BAD_BEEF);
    run_instr(7'h20, 8'd3, 2'd2, 2'd0, 3, 1'b0, "t3");

    // 8-bit with one masked byte inside a word
    elem_d[0] = 32'hA1; elem_d[1] = 32'hB2; elem_d[2] = 32'hC3; elem_d[3] = 32'hD4;
    elem_m[0] = 1'b1; elem_m[1] = 1'b0; elem_m[2] = 1'b1; elem_m[3] = 1'b1;
    push_exp(7'h40, 4'hD, 32'hD4C3_00A1);
    run_instr(7'h40, 8'd4, 2'd0, 2'd0, 4, 1'b0, "t4");

    // vsew=16b + widening -> 32b (saturation path)
    elem_d[0] = 32'hDEAD_BEEF; elem_d[1] = 32'h0123_4567;
    elem_m[0] = 1'b1; elem_m[1] = 1'b1;
    push_exp(7'h50, 4'hF, 32'hDEAD_BEEF);
    push_exp(7'h51, 4'hF, 32'h0123_4567);
    run_instr(7'h50, 8'd2, 2'd1, 2'd1, 2, 1'b0, "t5");

    // test 1 under write backpressure
    load_t1(); expect_t1();
    bus.wr_ready = 1'b0;
    run_instr(7'h10, 8'd6, 2'd0, 2'd0, 6, 1'b1, "t6bp");
    bus.wr_ready = 1'b1;

    // vl=0, with start re-asserted while busy and in the done cycle
    wr_before = n_wr;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.vd_addr = 7'h60; bus.vl = 8'd0; bus.vsew = 2'd0; bus.widening = 2'd0;
    @(posedge clk); #1;
    bus.vl = 8'd3;
    @(negedge clk);
    chk_eq("vl0_c1_busy_done", {bus.busy, bus.done}, 2'b10);
    @(negedge clk);
    chk_eq("vl0_c2_busy_done", {bus.busy, bus.done}, 2'b11);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk_eq("vl0_c3_busy_done", {bus.busy, bus.done}, 2'b00);
    chk_eq("vl0_c3_state", dbg_state, 0);
    @(negedge clk);
    chk_eq("vl0_ignored_start", {bus.busy, bus.pe_ready}, 2'b00);
    chk_eq("vl0_no_write", n_wr, wr_before);

    // reset after 2 accepts of test 1, then a clean rerun
    load_t1();
    start_instr(7'h10, 8'd6, 2'd0, 2'd0);
    send_elem(elem_d[0], elem_m[0]);
    send_elem(elem_d[1], elem_m[1]);
    bus.pe_valid = 1'b0;
    #2 n_reset = 1'b0;
    #1 check_idle("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) n_reset = 1'b1;
    chk_eq("mid_reset_no_write", n_wr, wr_before);
    load_t1(); expect_t1();
    run_instr(7'h10, 8'd6, 2'd0, 2'd0, 6, 1'b0, "t1_again");

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
